// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO controller driving an external 16x8 register RAM with pointers, occupancy and flags.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAG_EN.
module fifo_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push_acc;
  logic              pop_acc;
  logic              vld_p1;

  // Stage p0: acceptance against registered flags, RAM strobes, next occupancy
  always_comb begin
    push_acc  = push & ~full;
    pop_acc   = pop & ~empty;
    count_nxt = count;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  assign ram_wr_en   = push_acc;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = push_data;
  assign ram_rd_en   = pop_acc;
  assign ram_rd_addr = rd_ptr;

  // Stage p1: pointers, count, flags and read-valid register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      full   <= (count_nxt == DEPTH_CNT);
      empty  <= (count_nxt == '0);
      vld_p1 <= pop_acc;
    end
  end

  // RAM read data is registered inside the RAM, so it lines up with vld_p1
  assign pop_valid = vld_p1;
  assign pop_data  = ram_rd_data;

`ifdef FIFO_ERR_FLAG_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full) overflow  <= 1'b1;
      if (pop & empty) underflow <= 1'b1;
    end
  end
`endif

endmodule
